router_out_port: RTL and testbench
==================================

# router_out_port

Output-port buffer for the 2x4 mesh router, one instance per output direction (X, Y, local), placed between the crossbar and the outgoing link. It accepts switched flits from the crossbar and stores them in a small FIFO feeding a registered link stage. It drives the link with a valid/ready handshake. It generates the `full` indication that the router's per-port flow control uses to grant input FIFOs.

## Interface
Parameters:
- `DATA_WIDTH`, 16: flit width in bits.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH+1)`: width of `count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  crossbar presents a flit this cycle.
- `in_data`  in  DATA_WIDTH  flit from crossbar.
- `full`  out  1  FIFO holds DEPTH entries; the crossbar must not write.
- `empty`  out  1  FIFO and link register both empty.
- `count`  out  CNT_W  FIFO occupancy, excluding the link register.
- `tx_valid`  out  1  link register holds a flit.
- `tx_data`  out  DATA_WIDTH  link register contents.
- `tx_ready`  in  1  downstream accepts the flit when `tx_valid && tx_ready`.
- `stall_cnt`  out  16  present only with `OUTPORT_STATS_EN`.

## Operation
- Storage is a DEPTH-entry circular FIFO with `wr_ptr`/`rd_ptr` of width `$clog2(DEPTH)`, wrapping modulo DEPTH, plus one link register (`tx_data`/`tx_valid`). Total capacity is DEPTH+1 flits.
- Write accept condition: `in_valid && !full`. When `in_valid && full`, the flit is discarded and no state changes. Flow control upstream guarantees this never happens.
- Link register load: the register is "free" when `!tx_valid || tx_ready`. When free:
  - If the FIFO is non-empty, load the FIFO head, pop, and advance `rd_ptr`.
  - Else, if a write is accepted this cycle, load `in_data` directly. This is the bypass; the FIFO is untouched.
  - Else, `tx_valid` goes to 0.
- An accepted write that does not bypass pushes to `wr_ptr`.
- `count` next value = count + push − pop. A simultaneous push and pop leaves `count` unchanged, including when count = DEPTH.
- FIFO order is strict. The bypass applies only when the FIFO is empty, so ordering is preserved.
- Outputs on reset: `tx_valid`=0, `tx_data`=0, `count`=0, `full`=0, `empty`=1, pointers=0, `stall_cnt`=0.
- Reset mid-operation discards all flits immediately (asynchronously).

## Timing
- `full` = (count == DEPTH), decoded from registered state only. There is no combinational path from `tx_ready` or `in_valid` to `full`. A pop in cycle N deasserts `full` in cycle N+1.
- `empty` = (count == 0) && !tx_valid, also from registered state only.
- Latency: a flit accepted at edge N into an idle port has `tx_valid`=1 after edge N (one cycle).
- Throughput: one flit per cycle with `tx_ready` held high, whether or not the FIFO is empty.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` is held stable.
- `tx_valid` never deasserts without a completed handshake, except on reset.

## Configuration
- Macro: `OUTPORT_STATS_EN`.
- Defined: adds the `stall_cnt` output, a 16-bit counter incremented every cycle with `tx_valid && !tx_ready`. It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter do not exist. Datapath behaviour is identical in both builds.

## Test plan
- Idle pass-through: write 16'hA5A5 with `tx_ready`=1 → `tx_valid`=1 with 16'hA5A5 exactly one cycle later; `count` stays 0.
- Fill: with `tx_ready`=0, write 6 flits 1..6 back-to-back (DEPTH=4) → flit 1 sits in the link register, `count` reaches 4, `full`=1 from the cycle after the 5th write, flit 6 is dropped. Then release `tx_ready` → order 1,2,3,4,5 out, `empty`=1 afterwards.
- Simultaneous push/pop at full: count=4, `tx_ready`=1, `in_valid`=0 for one cycle, then writes resume → no loss, no reorder, `count` returns to 4 within one cycle of `full` dropping.
- Pointer wrap: stream 20 incrementing flits with random `tx_ready` (50%) and `in_valid` gated by `full` → output sequence 0..19 intact.
- Reset mid-stream: assert `rst_n`=0 with count=3 and `tx_valid`=1 → `tx_valid`, `count`, `full` clear immediately, `empty`=1; the first flit after reset is the first one out.
- Stats (with `OUTPORT_STATS_EN`): hold `tx_valid`=1, `tx_ready`=0 for 10 cycles → `stall_cnt`=10; force 70000 stall cycles → `stall_cnt`=16'hFFFF.

Source files
------------

// File: rtl/router_out_port.sv
// Output-port buffer: DEPTH-entry FIFO feeding a registered valid/ready link stage.
// Optional OUTPORT_STATS_EN adds a saturating link-stall counter (stall_cnt).
module router_out_port #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output logic                  tx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_ready
`ifdef OUTPORT_STATS_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_nxt;

   logic wr_acc;
   logic fifo_empty;
   logic link_free;
   logic pop;
   logic bypass;
   logic push;

   assign count = cnt;
   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0) && !tx_valid;

   assign wr_acc     = in_valid && !full;
   assign fifo_empty = (cnt == '0);
   assign link_free  = !tx_valid || tx_ready;
   assign pop        = link_free && !fifo_empty;
   // Bypass only when the FIFO is empty, so order is preserved.
   assign bypass     = link_free && fifo_empty && wr_acc;
   assign push       = wr_acc && !bypass;

   always_comb begin
      cnt_nxt = cnt;
      unique case ({push, pop})
         2'b10:   cnt_nxt = cnt + CNT_W'(1);
         2'b01:   cnt_nxt = cnt - CNT_W'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            tx_valid <= 1'b1;
            tx_data  <= mem[rd_ptr];
         end else if (bypass) begin
            tx_valid <= 1'b1;
            tx_data  <= in_data;
         end else if (link_free) begin
            tx_valid <= 1'b0;
         end
      end
   end

`ifdef OUTPORT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (tx_valid && !tx_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_router_out_port.sv
// Bench for router_out_port: vector table, directed corner sequences and
// randomized streaming checked against a flit-queue reference model.
module tb_router_out_port;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [DW-1:0]    in_data;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic             tx_valid;
   logic [DW-1:0]    tx_data;
   logic             tx_ready;
`ifdef OUTPORT_STATS_EN
   logic [15:0]      stall_cnt;
`endif

   router_out_port #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_data(in_data),
      .full(full),
      .empty(empty),
      .count(count),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_ready(tx_ready)
`ifdef OUTPORT_STATS_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: every flit held by the port (link register + FIFO), oldest first.
   logic [DW-1:0] mq [$];
   logic [DW-1:0] got [$];

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          r;
      logic          e_tv;
      logic [DW-1:0] e_td;
      int            e_cnt;
      logic          e_full;
      logic          e_empty;
   } vec_t;

   vec_t vt [$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      int sz;
      sz = mq.size();
      chk({tag, " tx_valid"}, int'(tx_valid), int'(sz > 0));
      if (sz > 0) chk({tag, " tx_data"}, int'(tx_data), int'(mq[0]));
      chk({tag, " count"}, int'(count), (sz > 0) ? sz - 1 : 0);
      chk({tag, " full"}, int'(full), int'(sz == DEPTH + 1));
      chk({tag, " empty"}, int'(empty), int'(sz == 0));
   endtask

   // One clock with model update; inputs change and outputs are sampled 1ns after the edge.
   task automatic step(input logic iv, input logic [DW-1:0] d, input logic r,
                       input string tag);
      logic acc;
      logic pm;
      in_valid = iv;
      in_data  = d;
      tx_ready = r;
      #1;
      if (tx_valid && r) got.push_back(tx_data);
      acc = iv && (mq.size() != DEPTH + 1);
      pm  = (mq.size() > 0) && r;
      if (pm) void'(mq.pop_front());
      if (acc) mq.push_back(d);
      @(posedge clk);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tx_ready = 1'b0;
      mq.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tx_ready = 1'b0;
      #2;
      chk("reset tx_valid", int'(tx_valid), 0);
      chk("reset tx_data", int'(tx_data), 0);
      chk("reset count", int'(count), 0);
      chk("reset full", int'(full), 0);
      chk("reset empty", int'(empty), 1);
`ifdef OUTPORT_STATS_EN
      chk("reset stall_cnt", int'(stall_cnt), 0);
`endif
      do_reset();

      // Pass-through then fill-to-full with drop, then drain in order.
      vt.push_back('{1, 16'hA5A5, 1, 1, 16'hA5A5, 0, 0, 0});
      vt.push_back('{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1});
      vt.push_back('{1, 16'd1, 0, 1, 16'd1, 0, 0, 0});
      vt.push_back('{1, 16'd2, 0, 1, 16'd1, 1, 0, 0});
      vt.push_back('{1, 16'd3, 0, 1, 16'd1, 2, 0, 0});
      vt.push_back('{1, 16'd4, 0, 1, 16'd1, 3, 0, 0});
      vt.push_back('{1, 16'd5, 0, 1, 16'd1, 4, 1, 0});
      vt.push_back('{1, 16'd6, 0, 1, 16'd1, 4, 1, 0});
      vt.push_back('{0, 16'd0, 1, 1, 16'd2, 3, 0, 0});
      vt.push_back('{0, 16'd0, 1, 1, 16'd3, 2, 0, 0});
      vt.push_back('{0, 16'd0, 1, 1, 16'd4, 1, 0, 0});
      vt.push_back('{0, 16'd0, 1, 1, 16'd5, 0, 0, 0});
      vt.push_back('{0, 16'd0, 1, 0, 16'd0, 0, 0, 1});
      for (int i = 0; i < vt.size(); i++) begin
         in_valid = vt[i].iv;
         in_data  = vt[i].d;
         tx_ready = vt[i].r;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d tx_valid", i), int'(tx_valid), int'(vt[i].e_tv));
         if (vt[i].e_tv)
            chk($sformatf("vec%0d tx_data", i), int'(tx_data), int'(vt[i].e_td));
         chk($sformatf("vec%0d count", i), int'(count), vt[i].e_cnt);
         chk($sformatf("vec%0d full", i), int'(full), int'(vt[i].e_full));
         chk($sformatf("vec%0d empty", i), int'(empty), int'(vt[i].e_empty));
      end

      // Pop at full, then writes refill while the link stalls.
      for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h10 + i), 1'b0, "fillpp");
      chk("pp full", int'(full), 1);
      step(1'b0, '0, 1'b1, "pp pop");
      step(1'b1, 16'h15, 1'b0, "pp refill");
      chk("pp full again", int'(full), 1);
      step(1'b1, 16'h16, 1'b1, "pp at full");
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "pp drain");

      // Random ready with writes gated by full: 20 flits through wrapping pointers.
      begin
         int nxt;
         int cyc;
         got.delete();
         nxt = 0;
         cyc = 0;
         while ((nxt < 20 || !empty) && cyc < 500) begin
            logic iv;
            iv = (nxt < 20) && !full;
            step(iv, DW'(nxt), 1'($urandom_range(0, 1)), "wrap");
            if (iv) nxt++;
            cyc++;
         end
         chk("wrap finished in budget", int'(cyc < 500), 1);
         chk("wrap out count", got.size(), 20);
         for (int i = 0; i < got.size() && i < 20; i++)
            chk($sformatf("wrap order %0d", i), int'(got[i]), i);
      end

      // Asynchronous reset with three flits in the FIFO and one in the link.
      for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h30 + i), 1'b0, "prerst");
      chk("prerst count", int'(count), 3);
      in_valid = 1'b0;
      rst_n = 1'b0;
      mq.delete();
      #1;
      chk("async rst tx_valid", int'(tx_valid), 0);
      chk("async rst count", int'(count), 0);
      chk("async rst full", int'(full), 0);
      chk("async rst empty", int'(empty), 1);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 16'h77, 1'b0, "postrst");
      step(1'b1, 16'h78, 1'b1, "postrst");
      step(1'b0, '0, 1'b1, "postrst");
      step(1'b0, '0, 1'b1, "postrst");

`ifdef OUTPORT_STATS_EN
      do_reset();
      step(1'b1, 16'h55, 1'b0, "stall");
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, "stall");
      chk("stall_cnt 10", int'(stall_cnt), 10);
      in_valid = 1'b0;
      tx_ready = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      chk("stall_cnt sat", int'(stall_cnt), 16'hFFFF);
      chk("stall hold tx_data", int'(tx_data), 16'h55);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
